// File: rtl/lsu_dmem_master.sv
// lsu_dmem_master: load/store initiator for a word-addressed data memory; sub-word stores use read-modify-write.
// Optional LSU_RANGE_CHECK_EN: word index >= MEM_WORDS returns an error without touching memory.
module lsu_dmem_master #(
    parameter int MEM_WORDS  = 256,
    parameter bit BIG_ENDIAN = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_write,
    input  logic [31:0] mem_rdata
);
    typedef enum logic [2:0] {IDLE, LOAD, STORE, RMW_RD, RMW_WR, RESP} state_e;
    state_e      state_q, state_d;
    logic        sgn_q, err_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q, wdata_q, word_q, word_d, rdata_q, rdata_d;
    logic        accept, req_err, range_err;
    logic [4:0]  sh;
    logic [31:0] lane, ext, mask, merged;
    assign accept = req_valid && req_ready;
`ifdef LSU_RANGE_CHECK_EN
    assign range_err = {2'b00, req_addr[31:2]} >= 32'(MEM_WORDS);
`else
    assign range_err = MEM_WORDS < 0;
`endif
    assign req_err = (req_size == 2'b11) || (req_size == 2'b01 && req_addr[0])
                  || (req_size == 2'b10 && |req_addr[1:0]) || range_err;
    // Lane bit offset; BIG_ENDIAN mirrors the byte/half position within the word.
    assign sh     = size_q == 2'b00 ? {addr_q[1:0] ^ {2{BIG_ENDIAN}}, 3'b000} : {addr_q[1] ^ BIG_ENDIAN, 4'b0000};
    assign lane   = mem_rdata >> sh;
    assign ext    = size_q == 2'b00 ? {{24{sgn_q & lane[7]}}, lane[7:0]}
                  : size_q == 2'b01 ? {{16{sgn_q & lane[15]}}, lane[15:0]} : mem_rdata;
    assign mask   = (size_q == 2'b00 ? 32'h0000_00FF : 32'h0000_FFFF) << sh;
    assign merged = (word_q & ~mask) | ((wdata_q << sh) & mask);
    always_comb begin
        state_d = state_q;
        rdata_d = rdata_q;
        word_d  = word_q;
        case (state_q)
            IDLE: if (accept) begin
                rdata_d = '0;
                state_d = req_err ? RESP : !req_write ? LOAD : req_size == 2'b10 ? STORE : RMW_RD;
            end
            LOAD: begin
                rdata_d = ext;
                state_d = RESP;
            end
            STORE:   state_d = RESP;
            RMW_RD: begin
                word_d  = mem_rdata;
                state_d = RMW_WR;
            end
            RMW_WR:  state_d = RESP;
            RESP:    state_d = resp_ready ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sgn_q   <= 1'b0;
            err_q   <= 1'b0;
            size_q  <= 2'b00;
            addr_q  <= '0;
            wdata_q <= '0;
            word_q  <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            rdata_q <= rdata_d;
            if (accept) begin
                sgn_q   <= req_signed;
                err_q   <= req_err;
                size_q  <= req_size;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
        end
    end
    assign req_ready  = state_q == IDLE;
    assign resp_valid = state_q == RESP;
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign mem_addr   = {2'b00, addr_q[31:2]};
    assign mem_write  = state_q == STORE || state_q == RMW_WR;
    assign mem_wdata  = state_q == STORE ? wdata_q : state_q == RMW_WR ? merged : '0;
endmodule

// File: tb/tb_lsu_dmem_master.sv
// tb_lsu_dmem_master: directed scoreboard bench for lsu_dmem_master with a 256-word behavioural memory.
module tb_lsu_dmem_master;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        req_valid = 1'b0, req_write = 1'b0, req_signed = 1'b0, resp_ready = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        req_ready, resp_valid, resp_err, mem_write;
    logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [31:0] mem [256];
    logic        poke_en = 1'b0;
    logic [7:0]  poke_idx = '0;
    logic [31:0] poke_val = '0;
    logic [31:0] last_waddr = '0;
    int checks = 0, failures = 0;
    typedef struct packed {logic [31:0] rd; logic err;} exp_t;
    exp_t sb[$];

    lsu_dmem_master dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;
    assign mem_rdata = mem[mem_addr[7:0]];
    always @(posedge clk) begin
        if (poke_en) mem[poke_idx] <= poke_val;
        else if (mem_write) mem[mem_addr[7:0]] <= mem_wdata;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [7:0] idx, input logic [31:0] val);
        @(negedge clk);
        poke_en = 1'b1; poke_idx = idx; poke_val = val;
        @(posedge clk); #1;
        poke_en = 1'b0;
    endtask

    // One request/response; hold = cycles resp_ready stays low after resp_valid rises.
    task automatic txn(input string tag, input logic w, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] d, input logic [31:0] erd,
                       input logic eerr, input int elat, input int hold);
        int n, wrs;
        exp_t e;
        sb.push_back('{rd: erd, err: eerr});
        @(negedge clk);
        chk({tag, ":req_ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg; req_addr = a; req_wdata = d;
        resp_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 1; wrs = 0;
        while (!resp_valid && n < 20) begin
            if (mem_write) begin
                wrs++;
                last_waddr = mem_addr;
            end
            @(posedge clk); #1;
            n++;
        end
        e = sb.pop_front();
        chk({tag, ":resp_valid"}, 32'(resp_valid), 32'd1);
        chk({tag, ":latency"}, 32'(n), 32'(elat));
        chk({tag, ":writes"}, 32'(wrs), 32'(w & ~eerr));
        chk({tag, ":rdata"}, resp_rdata, e.rd);
        chk({tag, ":err"}, 32'(resp_err), 32'(e.err));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk({tag, ":hold_valid"}, 32'(resp_valid), 32'd1);
            chk({tag, ":hold_rdata"}, resp_rdata, e.rd);
            chk({tag, ":hold_ready"}, 32'(req_ready), 32'd0);
            chk({tag, ":hold_write"}, 32'(mem_write), 32'd0);
        end
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        chk({tag, ":idle_valid"}, 32'(resp_valid), 32'd0);
        chk({tag, ":idle_ready"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst:req_ready", 32'(req_ready), 32'd1);
        chk("rst:resp_valid", 32'(resp_valid), 32'd0);
        chk("rst:resp_rdata", resp_rdata, 32'd0);
        chk("rst:resp_err", 32'(resp_err), 32'd0);
        chk("rst:mem_addr", mem_addr, 32'd0);
        chk("rst:mem_wdata", mem_wdata, 32'd0);
        chk("rst:mem_write", 32'(mem_write), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        // word store then word load
        txn("st_w", 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0, 2, 0);
        chk("st_w:waddr", last_waddr, 32'd4);
        chk("st_w:mem", mem[4], 32'hDEADBEEF);
        txn("ld_w", 0, 2'b10, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0, 2, 0);
        // byte store merges into existing word; upper wdata bits must be ignored
        poke(8'd4, 32'h11223344);
        txn("st_b", 1, 2'b00, 0, 32'h11, 32'h3456_78A5, 32'h0, 0, 3, 0);
        chk("st_b:mem", mem[4], 32'h1122A544);
        // sub-word loads with sign/zero extension
        poke(8'd4, 32'h80FFFFFF);
        txn("ld_bs13", 0, 2'b00, 1, 32'h13, 32'h0, 32'hFFFFFF80, 0, 2, 0);
        txn("ld_bu13", 0, 2'b00, 0, 32'h13, 32'h0, 32'h00000080, 0, 2, 0);
        txn("ld_hs12", 0, 2'b01, 1, 32'h12, 32'h0, 32'hFFFF80FF, 0, 2, 0);
        txn("ld_hu10", 0, 2'b01, 0, 32'h10, 32'h0, 32'h0000FFFF, 0, 2, 0);
        txn("ld_bu11", 0, 2'b00, 0, 32'h11, 32'h0, 32'h000000FF, 0, 2, 0);
        txn("st_h12", 1, 2'b01, 0, 32'h12, 32'hABCD1234, 32'h0, 0, 3, 0);
        chk("st_h12:mem", mem[4], 32'h1234FFFF);
        // misaligned and illegal-size requests
        txn("err_ldh13", 0, 2'b01, 1, 32'h13, 32'h0, 32'h0, 1, 1, 0);
        txn("err_stw12", 1, 2'b10, 0, 32'h12, 32'h55555555, 32'h0, 1, 1, 0);
        txn("err_sz3ld", 0, 2'b11, 0, 32'h10, 32'h0, 32'h0, 1, 1, 0);
        txn("err_sz3st", 1, 2'b11, 0, 32'h10, 32'h66666666, 32'h0, 1, 1, 0);
        chk("err:mem", mem[4], 32'h1234FFFF);
        // back-pressure, then an immediate follow-up request
        poke(8'd6, 32'h0BADF00D);
        txn("bp_ldw", 0, 2'b10, 0, 32'h18, 32'h0, 32'h0BADF00D, 0, 2, 5);
        txn("bp_next", 0, 2'b00, 0, 32'h18, 32'h0, 32'h0000000D, 0, 2, 0);
        poke(8'd0, 32'h5A5A0001);
`ifdef LSU_RANGE_CHECK_EN
        txn("range", 0, 2'b10, 0, 32'h400, 32'h0, 32'h0, 1, 1, 0);
`else
        txn("range", 0, 2'b10, 0, 32'h400, 32'h0, 32'h5A5A0001, 0, 2, 0);
`endif
        // reset during RMW_WR aborts the write
        poke(8'd5, 32'hCAFEF00D);
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_signed = 1'b0;
        req_addr = 32'h14; req_wdata = 32'h77;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        chk("rst_mid:mem_write_pre", 32'(mem_write), 32'd1);
        chk("rst_mid:mem_wdata_pre", mem_wdata, 32'hCAFEF077);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid:mem_write", 32'(mem_write), 32'd0);
        chk("rst_mid:mem_wdata", mem_wdata, 32'd0);
        chk("rst_mid:req_ready", 32'(req_ready), 32'd1);
        chk("rst_mid:resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_mid:mem_addr", mem_addr, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst_mid:mem", mem[5], 32'hCAFEF00D);
        txn("rst_mid_ld", 0, 2'b10, 0, 32'h14, 32'h0, 32'hCAFEF00D, 0, 2, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
